// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel debounced edge detector.
// Holds the edge-mode encoding and the edge qualification rule used by every channel.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_qualifies(input logic [1:0] mode, input logic rising);
        logic hit;
        hit = 1'b0;
        case (edge_mode_e'(mode))
            EDGE_RISE: hit = rising;
            EDGE_FALL: hit = !rising;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One debounced switch channel: 2-FF sync, integrating debounce, edge qualify,
// saturating event counter and retriggerable LED stretcher.
module edge_chan
    import edge_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int CNT_W          = 8,
    parameter int STRETCH_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             sw_in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             level,
    output logic             edge_pulse,
    output logic             led,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             s1;
    logic             s2;
    logic [DEB_W-1:0] deb_cnt;
    logic             accept;
    logic             pulse_d;

    // A new synced level is accepted on the DEB_CYCLES-th consecutive differing sample.
    assign accept  = (s2 != level) && (deb_cnt == DEB_LAST);
    assign pulse_d = accept && edge_qualifies(mode, s2);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            level      <= 1'b0;
            deb_cnt    <= '0;
            edge_pulse <= 1'b0;
        end else begin
            s1         <= sw_in;
            s2         <= s1;
            edge_pulse <= pulse_d;
            if (s2 == level) begin
                deb_cnt <= '0;
            end else if (accept) begin
                level   <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            evt_cnt <= '0;
        end else if (clr) begin
            evt_cnt <= '0;
        end else if (edge_pulse && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end

    generate
        if (STRETCH_CYCLES == 0) begin : g_no_stretch
            assign led = edge_pulse;
        end else begin : g_stretch
            localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
            logic [STR_W-1:0] str_cnt;
            logic [STR_W-1:0] str_next;

            // Reload alongside the pulse register so led lights in the pulse cycle itself.
            always_comb begin
                str_next = str_cnt;
                if (pulse_d) begin
                    str_next = STR_W'(STRETCH_CYCLES);
                end else if (str_cnt != '0) begin
                    str_next = str_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    str_cnt <= '0;
                    led     <= 1'b0;
                end else begin
                    str_cnt <= str_next;
                    led     <= (str_next != '0);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel debounced edge detector for push switches and slow GPIO.
// Each channel is an independent edge_chan; any_edge flags an event on any channel.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int CNT_W          = 8,
    parameter int STRETCH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [N_CH-1:0]       sw_in,
    input  logic [2*N_CH-1:0]     mode,
    input  logic                  clr,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       edge_pulse,
    output logic [N_CH-1:0]       led,
    output logic [CNT_W*N_CH-1:0] evt_cnt,
    output logic                  any_edge
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_chan #(
            .DEB_CYCLES     (DEB_CYCLES),
            .CNT_W          (CNT_W),
            .STRETCH_CYCLES (STRETCH_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rstb       (rstb),
            .sw_in      (sw_in[i]),
            .mode       (mode[2*i +: 2]),
            .clr        (clr),
            .level      (level[i]),
            .edge_pulse (edge_pulse[i]),
            .led        (led[i]),
            .evt_cnt    (evt_cnt[CNT_W*i +: CNT_W])
        );
    end

    assign any_edge = |edge_pulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random switch activity,
// checked every cycle against a sliding-window behavioural model.
module tb_multi_edge_detector;
    import edge_pkg::*;

    localparam int N_CH    = 2;
    localparam int DEB     = 4;
    localparam int CNT_W   = 8;
    localparam int STR     = 8;
    localparam int CNT_W_S = 2;

    logic                    clk = 1'b0;
    logic                    rstb = 1'b0;
    logic                    clr = 1'b0;
    logic [N_CH-1:0]         sw_in = '0;
    logic [2*N_CH-1:0]       mode = '0;

    logic [N_CH-1:0]         level, edge_pulse, led;
    logic [CNT_W*N_CH-1:0]   evt_cnt;
    logic                    any_edge;
    logic [N_CH-1:0]         level_s, edge_pulse_s, led_s;
    logic [CNT_W_S*N_CH-1:0] evt_cnt_s;
    logic                    any_edge_s;

    multi_edge_detector #(.N_CH(N_CH), .DEB_CYCLES(DEB), .CNT_W(CNT_W), .STRETCH_CYCLES(STR)) dut (
        .clk(clk), .rstb(rstb), .sw_in(sw_in), .mode(mode), .clr(clr),
        .level(level), .edge_pulse(edge_pulse), .led(led), .evt_cnt(evt_cnt), .any_edge(any_edge)
    );

    // Small counter, unstretched LED variant driven by the same stimulus.
    multi_edge_detector #(.N_CH(N_CH), .DEB_CYCLES(DEB), .CNT_W(CNT_W_S), .STRETCH_CYCLES(0)) dut_s (
        .clk(clk), .rstb(rstb), .sw_in(sw_in), .mode(mode), .clr(clr),
        .level(level_s), .edge_pulse(edge_pulse_s), .led(led_s), .evt_cnt(evt_cnt_s),
        .any_edge(any_edge_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw switch samples per edge; level flips when the last DEB synced samples
    // all disagree with it. Synced sample at edge k is the raw sample from edge k-2.
    bit q[N_CH][$];
    bit m_lvl[N_CH];
    bit m_pulse[N_CH];
    int m_cnt[N_CH];
    int m_last[N_CH];
    int edge_no = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            q[ch].delete();
            for (int j = 0; j < DEB + 2; j++) q[ch].push_back(1'b0);
            m_lvl[ch]   = 1'b0;
            m_pulse[ch] = 1'b0;
            m_cnt[ch]   = 0;
            m_last[ch]  = -1000;
        end
    endfunction

    function automatic void model_step();
        edge_no++;
        if (!rstb) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            bit all_diff;
            bit [1:0] md;
            q[ch].push_back(sw_in[ch]);
            void'(q[ch].pop_front());
            if (clr) m_cnt[ch] = 0;
            else if (m_pulse[ch]) m_cnt[ch]++;
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (q[ch][j] == m_lvl[ch]) all_diff = 1'b0;
            m_pulse[ch] = 1'b0;
            if (all_diff) begin
                m_lvl[ch] = !m_lvl[ch];
                md = mode[2*ch +: 2];
                m_pulse[ch] = (md == EDGE_BOTH) || (md == EDGE_RISE && m_lvl[ch]) ||
                              (md == EDGE_FALL && !m_lvl[ch]);
                if (m_pulse[ch]) m_last[ch] = edge_no;
            end
        end
    endfunction

    task automatic compare_all();
        bit any_m;
        any_m = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            any_m |= m_pulse[ch];
            check_val($sformatf("level[%0d]", ch), 32'(level[ch]), 32'(m_lvl[ch]));
            check_val($sformatf("edge_pulse[%0d]", ch), 32'(edge_pulse[ch]), 32'(m_pulse[ch]));
            check_val($sformatf("led[%0d]", ch), 32'(led[ch]), 32'((edge_no - m_last[ch]) < STR));
            check_val($sformatf("evt_cnt[%0d]", ch), 32'(evt_cnt[CNT_W*ch +: CNT_W]),
                      32'(sat(m_cnt[ch], (1 << CNT_W) - 1)));
            check_val($sformatf("level_s[%0d]", ch), 32'(level_s[ch]), 32'(m_lvl[ch]));
            check_val($sformatf("led_s[%0d]", ch), 32'(led_s[ch]), 32'(m_pulse[ch]));
            check_val($sformatf("evt_cnt_s[%0d]", ch), 32'(evt_cnt_s[CNT_W_S*ch +: CNT_W_S]),
                      32'(sat(m_cnt[ch], (1 << CNT_W_S) - 1)));
        end
        check_val("any_edge", 32'(any_edge), 32'(any_m));
        check_val("any_edge_s", 32'(any_edge_s), 32'(any_m));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int lit;
        model_reset();
        #2;
        compare_all();
        tick();
        tick();
        rstb = 1'b1;
        mode = {EDGE_BOTH, EDGE_RISE};
        repeat (3) tick();

        // Press ch0: level and pulse appear on the 6th edge after the change.
        sw_in[0] = 1'b1;
        repeat (5) tick();
        check_val("lat_edge5_level", 32'(level[0]), 32'd0);
        tick();
        check_val("lat_edge6_pulse", 32'(edge_pulse[0]), 32'd1);
        check_val("lat_edge6_led", 32'(led[0]), 32'd1);
        tick();
        check_val("lat_edge7_cnt", 32'(evt_cnt[7:0]), 32'd1);
        repeat (15) tick();
        sw_in[0] = 1'b0;
        repeat (20) tick();

        // Glitch of 3 clocks is ignored.
        sw_in[0] = 1'b1;
        repeat (3) tick();
        sw_in[0] = 1'b0;
        repeat (12) tick();
        check_val("glitch_cnt", 32'(evt_cnt[7:0]), 32'd1);

        // ch1 BOTH: two press/release cycles, then OFF.
        for (int k = 0; k < 4; k++) begin
            sw_in[1] = ~sw_in[1];
            repeat (12) tick();
        end
        check_val("both_cnt", 32'(evt_cnt[15:8]), 32'd4);
        mode[3:2] = EDGE_OFF;
        for (int k = 0; k < 2; k++) begin
            sw_in[1] = ~sw_in[1];
            repeat (12) tick();
        end
        check_val("off_cnt", 32'(evt_cnt[15:8]), 32'd4);

        // ch0 saturation of the small counter, then clr coincident with a pulse.
        for (int k = 0; k < 4; k++) begin
            sw_in[0] = 1'b1;
            repeat (10) tick();
            sw_in[0] = 1'b0;
            repeat (10) tick();
        end
        check_val("sat_small", 32'(evt_cnt_s[1:0]), 32'd3);
        check_val("sat_main", 32'(evt_cnt[7:0]), 32'd5);
        sw_in[0] = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_main", 32'(evt_cnt[7:0]), 32'd0);
        check_val("clr_small", 32'(evt_cnt_s[1:0]), 32'd0);
        sw_in[0] = 1'b0;
        repeat (20) tick();

        // Retrigger: rise and fall pulses 4 cycles apart keep led lit 4+8 cycles.
        mode[3:2] = EDGE_BOTH;
        lit = 0;
        sw_in[1] = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if (t == 4) sw_in[1] = 1'b0;
            tick();
            if (led[1]) lit++;
        end
        check_val("retrigger_led_cycles", 32'(lit), 32'd12);

        // Reset while ch1 led lit and ch0 mid-debounce; inputs held high across release.
        sw_in[1] = 1'b1;
        repeat (7) tick();
        sw_in[0] = 1'b1;
        repeat (2) tick();
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        compare_all();
        check_val("rst_led_now", 32'(led[1]), 32'd0);
        repeat (2) tick();
        rstb = 1'b1;
        repeat (5) tick();
        check_val("post_rst_edge5", 32'(any_edge), 32'd0);
        tick();
        check_val("post_rst_edge6_any", 32'(any_edge), 32'd1);
        check_val("post_rst_edge6_pulses", 32'(edge_pulse), 32'd3);
        repeat (10) tick();

        // Random switch activity, mode changes, clears and occasional resets.
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 5) == 0) sw_in[0] = ~sw_in[0];
            if ($urandom_range(0, 4) == 0) sw_in[1] = ~sw_in[1];
            if ($urandom_range(0, 60) == 0) mode = 4'($urandom);
            clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 500) == 0) begin
                rstb = 1'b0;
                model_reset();
                #1;
                compare_all();
                tick();
                rstb = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
